// File: rtl/mult_unit.sv
// Iterative shift-add multiplier: WIDTH magnitude steps followed by a sign fixup,
// then a one-cycle register-file write of the low half of the product.
module mult_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              signed_op_i,
  input  logic [WIDTH-1:0]  rs_data_i,
  input  logic [WIDTH-1:0]  rt_data_i,
  input  logic [ADDR_W-1:0] dest_reg_i,
  output logic              busy_o,
  output logic              reg_write_o,
  output logic [ADDR_W-1:0] write_register_o,
  output logic [WIDTH-1:0]  write_data_o,
  output logic [WIDTH-1:0]  product_hi_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [2*WIDTH:0]  acc_q, acc_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  hi_q, hi_d;

  logic [WIDTH-1:0]   rsMag, rtMag;
  logic [WIDTH:0]     upperSum;
  logic [2*WIDTH-1:0] magProduct, finalProduct;
  logic               lastStep;

  // The accumulator's low half starts out holding the multiplier; its LSB picks each add.
  always_comb begin
    rsMag        = (signed_op_i && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
    rtMag        = (signed_op_i && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;
    upperSum     = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
    magProduct   = {upperSum, acc_q[WIDTH-1:1]};
    finalProduct = sign_q ? -magProduct : magProduct;
    lastStep     = (count_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    dest_d  = dest_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          mcand_d = rsMag;
          acc_d   = {{(WIDTH + 1){1'b0}}, rtMag};
          sign_d  = signed_op_i & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
          dest_d  = dest_reg_i;
          count_d = '0;
        end
      end
      RUN: begin
        acc_d   = {1'b0, magProduct};
        count_d = count_q + 1'b1;
        if (lastStep) begin
          state_d = DONE;
          wdata_d = finalProduct[WIDTH-1:0];
          hi_d    = finalProduct[2*WIDTH-1:WIDTH];
          wreg_d  = dest_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      dest_q  <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      dest_q  <= dest_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign reg_write_o      = (state_q == DONE);
  assign write_register_o = wreg_q;
  assign write_data_o     = wdata_q;
  assign product_hi_o     = hi_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner products, an ignored restart,
// a mid-run reset and randomized operands against an arithmetic reference.
module tb_mult_unit;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              signedOp;
  logic [WIDTH-1:0]  rsData;
  logic [WIDTH-1:0]  rtData;
  logic [ADDR_W-1:0] destReg;
  logic              busy;
  logic              regWrite;
  logic [ADDR_W-1:0] writeRegister;
  logic [WIDTH-1:0]  writeData;
  logic [WIDTH-1:0]  productHi;

  int vectorCount = 0;
  int missCount   = 0;

  mult_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .signed_op_i     (signedOp),
    .rs_data_i       (rsData),
    .rt_data_i       (rtData),
    .dest_reg_i      (destReg),
    .busy_o          (busy),
    .reg_write_o     (regWrite),
    .write_register_o(writeRegister),
    .write_data_o    (writeData),
    .product_hi_o    (productHi)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one op from IDLE (called at a negedge); injectAt >= 0 pulses a stray start mid-run.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input logic [4:0] dst, input int injectAt);
    logic [63:0] expProd;
    int cyc;
    int pulses;
    expProd  = refProduct(a, b, sgn);
    start    = 1'b1;
    signedOp = sgn;
    rsData   = a;
    rtData   = b;
    destReg  = dst;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    rsData   = $urandom;
    rtData   = $urandom;
    destReg  = 5'($urandom);
    signedOp = 1'($urandom);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    cyc = 0;
    while (!regWrite && cyc < 100) begin
      if (cyc == injectAt) begin
        start    = 1'b1;
        signedOp = 1'b0;
        rsData   = 32'd9;
        rtData   = 32'd9;
        destReg  = 5'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("write_latency", 64'(cyc), 64'(WIDTH));
    checkOutput("write_register", 64'(writeRegister), 64'(dst));
    checkOutput("write_data", 64'(writeData), 64'(expProd[31:0]));
    checkOutput("product_hi", 64'(productHi), 64'(expProd[63:32]));
    checkOutput("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("reg_write_one_cycle", 64'(regWrite), 64'd0);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("write_data_held", 64'(writeData), 64'(expProd[31:0]));
    checkOutput("product_hi_held", 64'(productHi), 64'(expProd[63:32]));
    if (injectAt >= 0) begin
      pulses = 0;
      repeat (40) begin
        @(negedge clk);
        if (regWrite) pulses++;
      end
      checkOutput("no_extra_write", 64'(pulses), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] corners [4];
    logic [31:0] a;
    logic [31:0] b;
    int pulses;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h8000_0000;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h7FFF_FFFF;

    rst = 1'b1; start = 1'b0; signedOp = 1'b0;
    rsData = '0; rtData = '0; destReg = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_reg_write", 64'(regWrite), 64'd0);
    checkOutput("reset_write_register", 64'(writeRegister), 64'd0);
    checkOutput("reset_write_data", 64'(writeData), 64'd0);
    checkOutput("reset_product_hi", 64'(productHi), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed products");
    applyStimulus(32'd7, 32'd6, 1'b0, 5'd3, -1);
    applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b1, 5'd4, -1);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd5, -1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd6, -1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd0, -1);

    $display("[TB] restart while busy");
    applyStimulus(32'd1234, 32'd5678, 1'b0, 5'd9, 4);

    $display("[TB] reset mid-run");
    start = 1'b1; signedOp = 1'b0; rsData = 32'd123456; rtData = 32'd789; destReg = 5'd11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_reg_write", 64'(regWrite), 64'd0);
    checkOutput("abort_write_data", 64'(writeData), 64'd0);
    checkOutput("abort_product_hi", 64'(productHi), 64'd0);
    checkOutput("abort_write_register", 64'(writeRegister), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (regWrite) pulses++;
    end
    checkOutput("abort_no_write", 64'(pulses), 64'd0);
    applyStimulus(32'd2, 32'd2, 1'b0, 5'd12, -1);

    $display("[TB] randomized products");
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      applyStimulus(a, b, 1'($urandom), 5'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
